debounce_evt_ctrl: RTL

Event controller behind the multi-channel `debouncer`. It detects rising and falling edges on each `debounced_signal` bit and holds one pending event per channel. A round-robin arbiter shares a single valid/ready event port among all channels; the port feeds the core's MMIO input register. Edges that arrive while a channel's event is still unconsumed are dropped, and a sticky overflow flag is set.

---
 rtl/debounce_pkg.sv | 14 +
 rtl/debounce_evt_ctrl_if.sv | 24 ++
 rtl/debounce_evt_ctrl_rr_pick.sv | 27 ++
 rtl/debounce_evt_ctrl.sv | 134 +++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared encodings for the debouncer event path.
package debounce_pkg;

    // Event port FSM states.
    typedef enum logic {
        EVT_IDLE    = 1'b0,
        EVT_PRESENT = 1'b1
    } evt_state_e;

    // Event type as carried on evt_rise and stored per channel.
    localparam logic EVT_FALL = 1'b0;
    localparam logic EVT_RISE = 1'b1;

endpackage

// File: rtl/debounce_evt_ctrl_if.sv
// Valid/ready event port between the event controller and the MMIO input register.
interface debounce_evt_ctrl_if #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned IDX_W = $clog2(WIDTH)
);
    logic             evt_valid;
    logic             evt_ready;
    logic [IDX_W-1:0] evt_chan;
    logic             evt_rise;

    modport master (
        output evt_valid,
        output evt_chan,
        output evt_rise,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_chan,
        input  evt_rise,
        output evt_ready
    );
endinterface

// File: rtl/debounce_evt_ctrl_rr_pick.sv
// Combinational round-robin picker: first set request after 'last', wrapping.
module rr_pick #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_any
);

    // Scan WIDTH candidates starting one past the last grant; first hit wins.
    always_comb begin
        int unsigned cand;
        cand    = 0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int unsigned k = 1; k <= WIDTH; k++) begin
            cand = (int'(last) + k) % WIDTH;
            if (!gnt_any && req[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/debounce_evt_ctrl.sv
// Edge-to-event controller: per-channel edge detect, one pending event per
// channel, and a round-robin arbiter onto a single valid/ready event port.
module debounce_evt_ctrl
    import debounce_pkg::*;
#(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned IDX_W = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     debounced_signal,
    input  logic [WIDTH-1:0]     rise_en,
    input  logic [WIDTH-1:0]     fall_en,
    debounce_evt_ctrl_if.master  evt,
    output logic [WIDTH-1:0]     pending,
    output logic                 overflow,
    input  logic                 clr_ovf
);

    evt_state_e       state_q, state_d;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic [WIDTH-1:0] ptype_q, ptype_d;
    logic [IDX_W-1:0] chan_q, chan_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic             rise_q, rise_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] rise_edge, fall_edge, any_edge;
    logic [WIDTH-1:0] consume_vec, drop;
    logic             consume;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_any;

    assign rise_edge = debounced_signal & ~prev_q & rise_en;
    assign fall_edge = ~debounced_signal & prev_q & fall_en;
    assign any_edge  = rise_edge | fall_edge;

    rr_pick #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req     (pending_q),
        .last    (last_q),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    // Event port FSM: pick a pending channel when idle, hold it until accepted.
    always_comb begin
        state_d = state_q;
        chan_d  = chan_q;
        rise_d  = rise_q;
        last_d  = last_q;
        consume = 1'b0;
        unique case (state_q)
            EVT_IDLE: begin
                if (gnt_any) begin
                    chan_d  = gnt_idx;
                    rise_d  = ptype_q[gnt_idx];
                    state_d = EVT_PRESENT;
                end
            end
            EVT_PRESENT: begin
                if (evt.evt_ready) begin
                    consume = 1'b1;
                    last_d  = chan_q;
                    state_d = EVT_IDLE;
                end
            end
        endcase
    end

    // Pending table update; a consumed slot may be refilled by a same-cycle edge.
    always_comb begin
        consume_vec = '0;
        if (consume) begin
            consume_vec[chan_q] = 1'b1;
        end
        pending_d = pending_q;
        ptype_d   = ptype_q;
        drop      = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (any_edge[i]) begin
                if (!pending_q[i] || consume_vec[i]) begin
                    pending_d[i] = 1'b1;
                    ptype_d[i]   = rise_edge[i] ? EVT_RISE : EVT_FALL;
                end else begin
                    drop[i] = 1'b1;
                end
            end else if (consume_vec[i]) begin
                pending_d[i] = 1'b0;
            end
        end
        // A drop in the same cycle as clr_ovf must not be lost.
        if (|drop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= EVT_IDLE;
            prev_q    <= '0;
            pending_q <= '0;
            ptype_q   <= '0;
            chan_q    <= '0;
            rise_q    <= 1'b0;
            last_q    <= IDX_W'(WIDTH - 1);
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_q    <= debounced_signal;
            pending_q <= pending_d;
            ptype_q   <= ptype_d;
            chan_q    <= chan_d;
            rise_q    <= rise_d;
            last_q    <= last_d;
            ovf_q     <= ovf_d;
        end
    end

    assign evt.evt_valid = (state_q == EVT_PRESENT);
    assign evt.evt_chan  = chan_q;
    assign evt.evt_rise  = rise_q;
    assign pending       = pending_q;
    assign overflow      = ovf_q;

endmodule
